// File: rtl/joystick_splitter_scanner_if.sv
// Signal bundle between the DB9 splitter scanner and its surroundings.
// The scanner connects through the slave modport; the driving side uses master.
interface joystick_splitter_scanner_if #(
    parameter int unsigned NUM_JOYS = 2,
    parameter int unsigned BUTTONS  = 6
) ();
    localparam int unsigned SELW = (NUM_JOYS > 1) ? $clog2(NUM_JOYS) : 1;

    logic                         enable;
    logic [BUTTONS-1:0]           db9_in;
    logic [SELW-1:0]              sel_out;
    logic [NUM_JOYS-1:0]          af_en;
    logic [1:0]                   af_rate;
    logic                         vsync_n;
    logic [NUM_JOYS*BUTTONS-1:0]  joy_state;
    logic [NUM_JOYS-1:0]          changed;
    logic                         frame_done;

    modport master (
        output enable, db9_in, af_en, af_rate, vsync_n,
        input  sel_out, joy_state, changed, frame_done
    );

    modport slave (
        input  enable, db9_in, af_en, af_rate, vsync_n,
        output sel_out, joy_state, changed, frame_done
    );
endinterface

// File: rtl/joystick_splitter_scanner.sv
// Time-multiplexed scanner for joysticks sharing one DB9 port via a splitter:
// per-slot settle/sample/hold, per-channel debounce and vsync-based autofire.
module joystick_splitter_scanner #(
    parameter int unsigned NUM_JOYS    = 2,
    parameter int unsigned BUTTONS     = 6,
    parameter int unsigned SLOT_CLKS   = 140000,
    parameter int unsigned SETTLE_CLKS = 16,
    parameter int unsigned DEBOUNCE    = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    joystick_splitter_scanner_if.slave   bus
);
    localparam int unsigned SELW  = (NUM_JOYS > 1)  ? $clog2(NUM_JOYS)  : 1;
    localparam int unsigned SLOTW = (SLOT_CLKS > 1) ? $clog2(SLOT_CLKS) : 1;
    localparam int unsigned CNTW  = (DEBOUNCE > 1)  ? $clog2(DEBOUNCE)  : 1;
    localparam int unsigned JOYW  = NUM_JOYS * BUTTONS;
    localparam int unsigned FIRE1 = 4;

    localparam logic [1:0] ST_SETTLE = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [SLOTW-1:0]   slot_q, slot_d;
    logic [SELW-1:0]    sel_q, sel_d;
    logic               sample_c;

    logic [BUTTONS-1:0] last_q   [NUM_JOYS];
    logic [BUTTONS-1:0] last_d   [NUM_JOYS];
    logic [CNTW-1:0]    cnt_q    [NUM_JOYS];
    logic [CNTW-1:0]    cnt_d    [NUM_JOYS];
    logic [BUTTONS-1:0] stable_q [NUM_JOYS];
    logic [BUTTONS-1:0] stable_d [NUM_JOYS];

    logic [JOYW-1:0]     joy_q, joy_d;
    logic [NUM_JOYS-1:0] changed_q, changed_d;
    logic                frame_done_q, frame_done_d;

    logic                vs_q;
    logic [3:0]          vcnt_q;
    logic                phase_c;

    // Slot sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SETTLE;
            slot_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            sel_q   <= sel_d;
        end
    end

    // Slot sequencer next state; select only advances at the slot boundary
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q + SLOTW'(1);
        sel_d    = sel_q;
        sample_c = 1'b0;
        case (state_q)
            ST_SETTLE: begin
                if (slot_q == SLOTW'(SETTLE_CLKS - 1)) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                sample_c = 1'b1;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                if (slot_q == SLOTW'(SLOT_CLKS - 1)) begin
                    state_d = ST_SETTLE;
                    slot_d  = '0;
                    if (bus.enable && (sel_q != SELW'(NUM_JOYS - 1)))
                        sel_d = sel_q + SELW'(1);
                    else
                        sel_d = '0;
                end
            end
            default: begin
                state_d = ST_SETTLE;
                slot_d  = '0;
            end
        endcase
    end

    // Debounce: last holds raw pin polarity, stable holds active-high state
    always_comb begin
        changed_d = '0;
        for (int c = 0; c < int'(NUM_JOYS); c++) begin
            last_d[c]   = last_q[c];
            cnt_d[c]    = cnt_q[c];
            stable_d[c] = stable_q[c];
            if (sample_c && (sel_q == SELW'(c))) begin
                if (bus.db9_in == last_q[c]) begin
                    if (cnt_q[c] != CNTW'(DEBOUNCE - 1))
                        cnt_d[c] = cnt_q[c] + CNTW'(1);
                end else begin
                    cnt_d[c]  = '0;
                    last_d[c] = bus.db9_in;
                end
                if ((cnt_d[c] == CNTW'(DEBOUNCE - 1)) && (~bus.db9_in != stable_q[c])) begin
                    stable_d[c]  = ~bus.db9_in;
                    changed_d[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < int'(NUM_JOYS); c++) begin
                last_q[c]   <= '1;
                cnt_q[c]    <= '0;
                stable_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < int'(NUM_JOYS); c++) begin
                last_q[c]   <= last_d[c];
                cnt_q[c]    <= cnt_d[c];
                stable_q[c] <= stable_d[c];
            end
        end
    end

    // Vsync rising-edge counter driving the autofire phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q   <= 1'b1;
            vcnt_q <= '0;
        end else begin
            vs_q <= bus.vsync_n;
            if (bus.vsync_n && !vs_q) vcnt_q <= vcnt_q + 4'd1;
        end
    end

    assign phase_c = vcnt_q[bus.af_rate];

    // Output mapping; joy_state lines up with the changed pulse
    always_comb begin
        joy_d = '0;
        for (int c = 0; c < int'(NUM_JOYS); c++) begin
            joy_d[c*BUTTONS +: BUTTONS] = stable_d[c];
            if (bus.af_en[c] && !phase_c) joy_d[c*BUTTONS + FIRE1] = 1'b0;
        end
        frame_done_d = sample_c &&
                       ((sel_q == SELW'(NUM_JOYS - 1)) || ((sel_q == '0) && !bus.enable));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            joy_q        <= '0;
            changed_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            joy_q        <= joy_d;
            changed_q    <= changed_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.sel_out    = sel_q;
    assign bus.joy_state  = joy_q;
    assign bus.changed    = changed_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_joystick_splitter_scanner.sv
// Directed bench for the joystick splitter scanner with a short slot period.
module tb_joystick_splitter_scanner;
    localparam int unsigned NJ = 2;
    localparam int unsigned NB = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   chg_cnt = 0;
    int   fd_cnt = 0;
    logic [NB-1:0] pat0 = 6'b111111;
    logic [NB-1:0] pat1 = 6'b111111;
    logic [3:0]    edges;

    joystick_splitter_scanner_if #(.NUM_JOYS(NJ), .BUTTONS(NB)) bus ();

    joystick_splitter_scanner #(
        .NUM_JOYS(NJ), .BUTTONS(NB), .SLOT_CLKS(64), .SETTLE_CLKS(4), .DEBOUNCE(3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Splitter model: each channel sees its own pin pattern
    always @(*) bus.db9_in = bus.sel_out[0] ? pat1 : pat0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst_n && (bus.changed != '0)) chg_cnt++;
        if (rst_n && bus.frame_done)      fd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic at(input int k);
        int guard;
        guard = 0;
        while (cyc < k && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < k) check("cycle_wait", 32'(cyc), 32'(k));
    endtask

    initial begin
        bus.enable  = 1'b1;
        bus.af_en   = '0;
        bus.af_rate = 2'd0;
        bus.vsync_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_sel", 32'(bus.sel_out), 0);
        check("rst_joy", 32'(bus.joy_state), 0);
        check("rst_chg", 32'(bus.changed), 0);
        check("rst_fd",  32'(bus.frame_done), 0);

        // Idle pins: select alternates, frame_done once per two slots
        at(10);  check("idle_sel0", 32'(bus.sel_out), 0);
        at(69);  check("idle_sel1", 32'(bus.sel_out), 1);
                 check("idle_fd1",  32'(bus.frame_done), 1);
        at(70);  check("idle_fd0",  32'(bus.frame_done), 0);
        at(134); check("idle_sel2", 32'(bus.sel_out), 0);
        at(197); check("idle_fd2",  32'(bus.frame_done), 1);
        at(250); check("idle_fdcnt", 32'(fd_cnt), 2);
                 check("idle_chg",  32'(chg_cnt), 0);
                 check("idle_joy",  32'(bus.joy_state), 0);

        // Channel 0 fire1 pressed: accepted on the third ch0 sample (cycle 516)
        pat0 = 6'b101111;
        at(516); check("ch0_pre",  32'(bus.joy_state), 0);
        at(517); check("ch0_joy",  32'(bus.joy_state), 32'h010);
                 check("ch0_chg",  32'(bus.changed), 1);
        at(518); check("ch0_chg0", 32'(bus.changed), 0);
        at(700); check("ch0_chgcnt", 32'(chg_cnt), 1);

        // Single-sample glitch on channel 1 is rejected
        pat1 = 6'b101111;
        at(720); pat1 = 6'b111111;
        at(1100); check("glitch_joy", 32'(bus.joy_state), 32'h010);
                  check("glitch_chg", 32'(chg_cnt), 1);

        // Channel 1 pressed, then splitter disabled mid ch0 slot
        pat1 = 6'b101111;
        at(1476); check("ch1_pre", 32'(bus.joy_state), 32'h010);
        at(1477); check("ch1_joy", 32'(bus.joy_state), 32'h410);
                  check("ch1_chg", 32'(bus.changed), 2);
        at(1550); bus.enable = 1'b0; pat1 = 6'b111111;
        at(1605); check("dis_fd1", 32'(bus.frame_done), 1);
                  check("dis_sel", 32'(bus.sel_out), 0);
        at(1669); check("dis_fd2", 32'(bus.frame_done), 1);
        at(1700); check("dis_sel2", 32'(bus.sel_out), 0);
        at(1800); check("dis_frozen", 32'(bus.joy_state), 32'h410);

        // Asynchronous reset during a channel 1 hold phase
        bus.enable = 1'b1;
        at(1900); check("hold_sel1", 32'(bus.sel_out), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sel", 32'(bus.sel_out), 0);
        check("arst_joy", 32'(bus.joy_state), 0);
        check("arst_fd",  32'(bus.frame_done), 0);
        bus.enable  = 1'b0;
        bus.af_rate = 2'd1;
        pat0 = 6'b101111;
        pat1 = 6'b111111;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_sel", 32'(bus.sel_out), 0);
        at(4);   check("rel_fd_early", 32'(bus.frame_done), 0);
        at(5);   check("rel_fd_first", 32'(bus.frame_done), 1);
        at(140); check("af_off_joy", 32'(bus.joy_state), 32'h010);

        // Autofire on channel 0 at rate bit 1
        bus.af_en = 2'b01;
        edges = 4'd0;
        for (int i = 0; i < 8; i++) begin
            repeat (3) @(negedge clk);
            check("af_seq", 32'(bus.joy_state[4]), 32'(edges[1]));
            bus.vsync_n = 1'b0;
            repeat (2) @(negedge clk);
            bus.vsync_n = 1'b1;
            edges = edges + 4'd1;
            repeat (3) @(negedge clk);
        end
        bus.af_en = 2'b00;
        repeat (2) @(negedge clk);
        check("af_dis_a", 32'(bus.joy_state[4]), 1);
        bus.vsync_n = 1'b0;
        repeat (2) @(negedge clk);
        bus.vsync_n = 1'b1;
        repeat (4) @(negedge clk);
        check("af_dis_b", 32'(bus.joy_state[4]), 1);
        check("af_ch1",   32'(bus.joy_state[11:6]), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
